// File: rtl/lab2_proc_imul_pkg.sv
// Shared types and width constants for the iterative integer multiplier.
// Request layout is {a, b} with the multiplicand in the upper word.
package lab2_proc_imul_pkg;

  localparam int IMUL_NBITS       = 32;
  localparam int IMUL_REQ_NBITS   = 64;
  localparam int IMUL_SHAMT_NBITS = 4;

  typedef struct packed {
    logic [IMUL_NBITS-1:0] a;
    logic [IMUL_NBITS-1:0] b;
  } imul_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } imul_state_t;

endpackage

// File: rtl/lab2_proc_imul_shamt.sv
// Trailing-zero count over the low p_max_skip multiplier bits, saturating
// at p_max_skip when the whole window is zero.
module lab2_proc_imul_shamt
  import lab2_proc_imul_pkg::*;
#(
  parameter int p_max_skip = 4
) (
  input  logic [p_max_skip-1:0]       bits,
  output logic [IMUL_SHAMT_NBITS-1:0] shamt
);

  logic found;

  // The lowest set bit wins; later set bits are ignored once one is found.
  always_comb begin
    shamt = IMUL_SHAMT_NBITS'(p_max_skip);
    found = 1'b0;
    for (int i = 0; i < p_max_skip; i++) begin
      if (!found && bits[i]) begin
        shamt = IMUL_SHAMT_NBITS'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lab2_proc_imul_iter.sv
// Iterative shift-add multiplier returning the low 32 bits of a*b.
// Runs of zero multiplier bits are retired up to p_max_skip per cycle.
//
// Handshake: a beat transfers on an edge where val && rdy are both high;
// istream_rdy only in IDLE, ostream_val only in DONE, both gated low while
// reset is asserted, and the result holds stable until ostream_rdy.
module lab2_proc_imul_iter
  import lab2_proc_imul_pkg::*;
#(
  parameter int p_max_skip = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      istream_val,
  output logic                      istream_rdy,
  input  logic [IMUL_REQ_NBITS-1:0] istream_msg,
  output logic                      ostream_val,
  input  logic                      ostream_rdy,
  output logic [IMUL_NBITS-1:0]     ostream_msg,
  output imul_state_t               dbg_state
);

  imul_req_t   req;
  imul_state_t state;
  imul_state_t state_nxt;
  logic        load_en;
  logic        calc_en;
  logic        b_step_zero;

  logic [IMUL_NBITS-1:0]       a_reg;
  logic [IMUL_NBITS-1:0]       b_reg;
  logic [IMUL_NBITS-1:0]       res_reg;
  logic [IMUL_NBITS-1:0]       a_step;
  logic [IMUL_NBITS-1:0]       b_step;
  logic [IMUL_NBITS-1:0]       res_step;
  logic [IMUL_SHAMT_NBITS-1:0] skip_sh;
  logic [IMUL_SHAMT_NBITS-1:0] step_sh;

  assign req = imul_req_t'(istream_msg);

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    calc_en   = 1'b0;
    case (state)
      IDLE: begin
        if (istream_val) begin
          load_en   = 1'b1;
          state_nxt = (req.b == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        calc_en = 1'b1;
        if (b_step_zero) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (ostream_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign istream_rdy = reset && (state == IDLE);
  assign ostream_val = reset && (state == DONE);
  assign dbg_state   = state;

  // ---------------- datapath ----------------
  lab2_proc_imul_shamt #(
    .p_max_skip (p_max_skip)
  ) u_shamt (
    .bits  (b_reg[p_max_skip-1:0]),
    .shamt (skip_sh)
  );

  // An add step is simply a one-bit shift that also accumulates.
  assign step_sh     = b_reg[0] ? IMUL_SHAMT_NBITS'(1) : skip_sh;
  assign res_step    = b_reg[0] ? (res_reg + a_reg) : res_reg;
  assign a_step      = a_reg << step_sh;
  assign b_step      = b_reg >> step_sh;
  assign b_step_zero = (b_step == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
    end else if (load_en) begin
      a_reg   <= req.a;
      b_reg   <= req.b;
      res_reg <= '0;
    end else if (calc_en) begin
      a_reg   <= a_step;
      b_reg   <= b_step;
      res_reg <= res_step;
    end
  end

  assign ostream_msg = res_reg;

endmodule

// File: tb/tb_lab2_proc_imul_iter.sv
// Directed plus randomized bench for lab2_proc_imul_iter; results and
// latencies come from a bit-gap model of the zero-skipping multiplier.
module tb_lab2_proc_imul_iter;
  import lab2_proc_imul_pkg::*;

  localparam int P = 4;

  logic        clk;
  logic        reset;
  logic        istream_val;
  logic        istream_rdy;
  logic [63:0] istream_msg;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [31:0] ostream_msg;
  imul_state_t dbg_state;

  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];

  lab2_proc_imul_iter #(
    .p_max_skip (P)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Each set bit costs one add step; each zero gap below a set bit costs
  // ceil(gap / P) skip steps.
  function automatic int model_steps(input logic [31:0] b);
    int steps;
    int gap;
    steps = 0;
    gap   = 0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        steps += 1 + (gap + P - 1) / P;
        gap = 0;
      end else begin
        gap++;
      end
    end
    return steps;
  endfunction

  function automatic logic [31:0] model_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = 64'(a) * 64'(b);
    return full[31:0];
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called and returns at a negedge. Issues one request, measures latency,
  // applies hold cycles of backpressure, then completes the output transfer.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int hold);
    int cyc;
    int exp_lat;
    cyc = 0;
    while (!istream_rdy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("in_rdy_before_issue", 32'(istream_rdy), 32'd1);

    istream_val = 1'b1;
    istream_msg = {a, b};
    exp_q.push_back(model_prod(a, b));
    exp_lat = (b == 32'd0) ? 1 : 1 + model_steps(b);
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    istream_msg = {$urandom, $urandom};

    @(negedge clk);
    cyc = 1;
    while (!ostream_val && cyc < 200) begin
      ostream_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    ostream_rdy = 1'b0;
    check("latency", 32'(cyc), 32'(exp_lat));
    check("result", ostream_msg, exp_q[0]);

    repeat (hold) begin
      istream_val = 1'b1;
      istream_msg = {$urandom, $urandom};
      @(negedge clk);
      check("hold_out_val", 32'(ostream_val), 32'd1);
      check("hold_out_msg", ostream_msg, exp_q[0]);
      check("hold_in_rdy", 32'(istream_rdy), 32'd0);
    end

    istream_val = 1'b0;
    ostream_rdy = 1'b1;
    @(posedge clk);
    #1;
    ostream_rdy = 1'b0;
    @(negedge clk);
    check("in_rdy_after_xfer", 32'(istream_rdy), 32'd1);
    check("out_val_after_xfer", 32'(ostream_val), 32'd0);
    check("msg_after_xfer", ostream_msg, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    n_vec       = 0;
    n_err       = 0;
    reset       = 1'b0;
    istream_val = 1'b1;
    istream_msg = {32'd9, 32'd9};
    ostream_rdy = 1'b0;

    // Reset held with a pending request: nothing accepted, outputs quiet.
    repeat (3) begin
      @(negedge clk);
      check("rst_in_rdy", 32'(istream_rdy), 32'd0);
      check("rst_out_val", 32'(ostream_val), 32'd0);
      check("rst_out_msg", ostream_msg, 32'd0);
    end
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset       = 1'b1;
    istream_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rdy_after_release", 32'(istream_rdy), 32'd1);
    check("no_accept_in_reset", 32'(ostream_val), 32'd0);

    // Directed corner cases.
    run_txn(32'd3, 32'd4, 0);
    run_txn(32'd5, 32'd0, 0);
    run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_txn(32'd7, 32'h8000_0000, 5);

    // Reset in the middle of a long computation.
    istream_val = 1'b1;
    istream_msg = {32'd1, 32'hFFFF_FFFF};
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("mid_state_calc", 32'(dbg_state), 32'(CALC));
    reset = 1'b0;
    #1;
    check("mid_rst_out_val", 32'(ostream_val), 32'd0);
    check("mid_rst_in_rdy", 32'(istream_rdy), 32'd0);
    check("mid_rst_out_msg", ostream_msg, 32'd0);
    @(negedge clk);
    check("mid_rst_held_val", 32'(ostream_val), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_txn(32'd6, 32'd7, 0);

    // Randomized operands with varied multiplier bit densities.
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom & $urandom & $urandom;
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = 32'd1 << $urandom_range(0, 31);
      endcase
      run_txn(ra, rb, $urandom_range(0, 3));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lab2_proc_imul_iter.md
# lab2_proc_imul_iter

Iterative, variable-latency 32-bit integer multiplier. It consumes the operand pair that the processor X stage issues for `mul`, and returns the low 32 bits of the product to the X-stage result mux. Both sides use val/rdy stream handshakes. The unit accepts one transaction at a time and skips runs of zero multiplier bits to shorten latency.

## Interface
- `p_max_skip`, default 4: maximum multiplier bits retired per cycle when the low bits are zero. Legal values are 1 to 8.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `reset` in, 1: asynchronous, active-low (asserted at 0). Clears all state immediately.
- `istream_val` in, 1: request valid.
- `istream_rdy` out, 1: unit can accept a request.
- `istream_msg` in, 64: request message; `[63:32]` = a (multiplicand), `[31:0]` = b (multiplier).
- `ostream_val` out, 1: result valid.
- `ostream_rdy` in, 1: consumer accepts the result.
- `ostream_msg` out, 32: product `(a*b) mod 2^32`.

## Operation
- **Registers**
  - `a_reg[31:0]`, `b_reg[31:0]`, `res_reg[31:0]`, 2-bit state.
  - All cleared to 0 / IDLE by reset.
- **State IDLE**
  - `istream_rdy=1`, `ostream_val=0`.
  - On `istream_val && istream_rdy`: load `a_reg=a`, `b_reg=b`, `res_reg=0`.
  - If b==0, go to DONE. Otherwise go to CALC.
- **State CALC** (one step per cycle)
  - If `b_reg[0]==1`: `res_reg += a_reg` (mod 2^32), `a_reg <<= 1`, `b_reg >>= 1` (logical).
  - Else: shift amount s = number of trailing zeros of `b_reg[p_max_skip-1:0]`. If those bits are all zero, s = p_max_skip. Apply `a_reg <<= s`, `b_reg >>= s`; `res_reg` is unchanged.
  - Go to DONE when the updated `b_reg==0`. Otherwise stay in CALC.
- **State DONE**
  - `ostream_val=1`, `ostream_msg=res_reg`, `istream_rdy=0`.
  - On `ostream_rdy`: go to IDLE.
  - No same-cycle accept of a new request (no bypass).
- **Arithmetic**
  - All arithmetic is unsigned, modulo 2^32.
  - The low-32 product is identical for signed operands, so no sign handling is needed.
  - Bits shifted out of `a_reg` are discarded.
- **Outputs**
  - `ostream_msg` is driven from `res_reg` in every state. It is 0 after reset.
  - `ostream_msg` changes only in CALC or on a load.

## Timing
- **Reset values:** `istream_rdy=0` while reset is asserted and 1 from the first edge after release. `ostream_val=0`. `ostream_msg=0`.
- **Latency:** request accepted at edge t.
  - b==0: `ostream_val` is high in cycle t+1.
  - Otherwise: `ostream_val` is high in cycle t+1+k, where k = number of CALC steps (each 1-bit add step or skip step counts 1).
  - Worst case is 32 steps (b=0xFFFFFFFF).
- **Output hold:** `ostream_val` and `ostream_msg` hold stable while `ostream_rdy=0`, for any number of cycles.
- **Throughput:** after the output transfer at edge u, `istream_rdy=1` in cycle u+1. The minimum issue interval is k+2 cycles.
- **Input side:** `istream_val` while not rdy is ignored. Nothing is latched, and the producer must hold.
- **Reset mid-operation:** reset asserted in CALC or DONE forces `ostream_val=0` and `istream_rdy=0` combinationally. The in-flight result is lost, with no partial output.
- **Simultaneous events:** `ostream_rdy` in IDLE or CALC has no effect. `istream_val` in DONE has no effect.

## Structure
- **Shared package `lab2_proc_imul_pkg`:**
  - `imul_req_t` packed struct {a[31:0], b[31:0]}, 64 bits.
  - `imul_state_t` enum {IDLE, CALC, DONE}.
  - Width constants: `IMUL_NBITS=32`, `IMUL_REQ_NBITS=64`.
- **Control and datapath:** split into ctrl (FSM, rdy/val, register enables) and dpath (`a_reg`, `b_reg`, `res_reg`, adder, shifters) within the file.
- **Sub-module `lab2_proc_imul_shamt`:** combinational trailing-zero count over `b_reg[p_max_skip-1:0]`. Outputs s, saturating at p_max_skip.

## Test plan
- **Reset:** hold reset=0 for 3 cycles with `istream_val=1`. Expect rdy=0, val=0, msg=0 during reset, no accept, and rdy=1 on the first cycle after release.
- **Small operands:** a=3, b=4 accepted at t. Expect 2 CALC steps, val high at t+3, msg=12.
- **Zero multiplier:** a=5, b=0 at t. Expect val at t+1, msg=0.
- **Worst case:** a=0xFFFFFFFF, b=0xFFFFFFFF at t. Expect val at t+33, msg=0x00000001.
- **Skip path and backpressure:** a=7, b=0x80000000 at t. Expect val at t+10, msg=0x80000000. Hold ostream_rdy=0 for 5 cycles: msg stays stable and `istream_rdy` stays 0. Then assert rdy: transfer occurs and `istream_rdy=1` on the next cycle.
- **Reset mid-CALC:** a=1, b=0xFFFFFFFF; assert reset at t+10. Expect val=0 immediately. After release, a=6, b=7 yields msg=42 at t'+4.
